instruction_fetch: RTL and testbench

Fetch sequencer directly upstream of program_memory. It owns the program counter, drives the ROM address and enable, and absorbs the ROM's one-cycle registered read latency. It presents each fetched word to the decode stage through a valid/ready handshake. It also supports branch redirect and a halt/resume mechanism.

---
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 tb/tb_instruction_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch sequencer sitting directly in front of program_memory. It owns the
//   program counter, drives the ROM address/enable, hides the ROM's one-cycle
//   registered read latency and hands each fetched word to decode over a
//   valid/ready handshake. Supports branch redirect and halt/resume.
//
//   Flow per instruction: ISSUE (address presented) -> WAIT (ROM data
//   valid, captured) -> HOLD (word offered to decode until accepted).
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   mem_address         ROM address (always equals the program counter)
//   mem_enable          ROM read enable, high only in ISSUE and WAIT
//   mem_data            ROM read data (only sampled in WAIT)
//   instr, instr_pc     captured word and the address it came from
//   instr_valid         instr/instr_pc valid
//   instr_ready         decode accepts instr this cycle
//   branch_valid        one-cycle redirect request
//   branch_target       redirect address
//   halt                stop after the current instruction is accepted
//   halted              high while halted
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter int s_addr = 6,
   parameter int s_word = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [s_addr-1:0] mem_address,
   output logic              mem_enable,
   input  logic [s_word-1:0] mem_data,
   output logic [s_word-1:0] instr,
   output logic [s_addr-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              branch_valid,
   input  logic [s_addr-1:0] branch_target,
   input  logic              halt,
   output logic              halted
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [s_addr-1:0] pc_q, pc_d;
   logic              mem_enable_q, mem_enable_d;
   logic [s_word-1:0] instr_q, instr_d;
   logic [s_addr-1:0] instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              halted_q, halted_d;

   // A branch wins over everything but reset; the cycle right after reset
   // release (IDLE) ignores it.
   logic redirect;
   assign redirect = branch_valid && (state_q != ST_IDLE);

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         mem_enable_q  <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         mem_enable_q  <= mem_enable_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         halted_q      <= halted_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = ST_ISSUE;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_HOLD;
            ST_HOLD:   if (instr_ready) state_d = halt ? ST_HALTED : ST_ISSUE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // -------------------------------------------------- datapath / output next
   always_comb begin
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;

      if (redirect) begin
         // Drops any in-flight WAIT capture and flushes a HOLD word, even one
         // being accepted this same cycle.
         pc_d          = branch_target;
         instr_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_WAIT: begin
               // mem_data is only looked at here, so Z/X elsewhere is harmless.
               instr_d       = mem_data;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + s_addr'(1);
            end
            ST_HOLD: begin
               if (instr_ready) instr_valid_d = 1'b0;
            end
            default: ;
         endcase
      end

      // Registered outputs derived from where the FSM is going next.
      mem_enable_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
      halted_d     = (state_d == ST_HALTED);
   end

   assign mem_address = pc_q;
   assign mem_enable  = mem_enable_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Drives instruction_fetch against a behavioural ROM. A stream-level model
//   tracks which address must be delivered next and how many cycles remain
//   before it appears; a negedge monitor compares the DUT against it.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   localparam int AW = 6;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] mem_address;
   logic          mem_enable;
   wire  [DW-1:0] mem_data;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic          branch_valid;
   logic [AW-1:0] branch_target;
   logic          halt;
   logic          halted;

   always #5 clk = ~clk;

   instruction_fetch #(.s_addr(AW), .s_word(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_address(mem_address), .mem_enable(mem_enable), .mem_data(mem_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .branch_valid(branch_valid),
      .branch_target(branch_target), .halt(halt), .halted(halted)
   );

   // ROM: registered read, data floats when the read was not enabled.
   logic [DW-1:0] rom [0:63];
   logic [DW-1:0] rd_q;
   logic          rd_en_q = 1'b0;
   always @(posedge clk) begin
      rd_en_q <= mem_enable;
      if (mem_enable) rd_q <= rom[mem_address];
   end
   assign mem_data = rd_en_q ? rd_q : 'z;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ model
   // q holds the address whose word decode must see next; cnt is the number
   // of clock edges before it shows up (0 = it is on offer now).
   int q[$];
   int cnt      = 0;
   int cur_pc   = 0;
   int hpc      = 0;
   bit pend     = 0;
   bit halted_m = 0;
   bit in_reset = 0;
   bit started  = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete(); in_reset = 1; started = 1; halted_m = 0; pend = 0; cnt = 0;
      end else if (in_reset) begin
         in_reset = 0; cur_pc = 0; q.push_back(0); pend = 1; cnt = 2;
      end else if (branch_valid) begin
         q.delete(); cur_pc = int'(branch_target); q.push_back(cur_pc);
         pend = 1; cnt = 2; halted_m = 0;
      end else if (pend && cnt == 0 && instr_ready) begin
         if (halt) begin
            pend = 0; halted_m = 1; hpc = (cur_pc + 1) % 64;
         end else begin
            cur_pc = (cur_pc + 1) % 64; q.push_back(cur_pc); cnt = 2;
         end
      end else if (cnt > 0) begin
         cnt--;
      end
   end

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (started && rst_n) begin
         if (in_reset) begin
            chk("rst_addr", 32'(mem_address), 0);
            chk("rst_en", 32'(mem_enable), 0);
            chk("rst_instr", 32'(instr), 0);
            chk("rst_ipc", 32'(instr_pc), 0);
            chk("rst_valid", 32'(instr_valid), 0);
            chk("rst_halted", 32'(halted), 0);
         end else if (q.size() > 0) begin
            chk("valid", 32'(instr_valid), (cnt == 0) ? 1 : 0);
            chk("halted_run", 32'(halted), 0);
            if (cnt == 0) begin
               chk("instr", 32'(instr), 32'(rom[q[0]]));
               chk("instr_pc", 32'(instr_pc), q[0]);
               chk("hold_en", 32'(mem_enable), 0);
               chk("hold_addr", 32'(mem_address), (q[0] + 1) % 64);
               if (instr_ready && !branch_valid) void'(q.pop_front());
            end else begin
               chk("fetch_en", 32'(mem_enable), 1);
               chk("fetch_addr", 32'(mem_address), q[0]);
            end
         end else if (halted_m) begin
            chk("halted", 32'(halted), 1);
            chk("halt_valid", 32'(instr_valid), 0);
            chk("halt_en", 32'(mem_enable), 0);
            chk("halt_addr", 32'(mem_address), hpc);
         end
      end
   end

   // -------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_branch(input int t);
      branch_valid  = 1'b1;
      branch_target = AW'(t);
      tick();
      branch_valid  = 1'b0;
   endtask

   task automatic wait_valid_pc(input int p);
      bit hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         tick();
         if (instr_valid === 1'b1 && instr_pc === AW'(p)) hit = 1;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL wait_pc actual=timeout expected=pc %0d t=%0t", p, $time);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = DW'($urandom);
      rom[0]  = 16'h1111;
      rom[1]  = 16'h2222;
      rom[2]  = 16'h3333;
      rom[63] = 16'hABCD;
      rst_n = 1'b0; instr_ready = 1'b1; branch_valid = 1'b0;
      branch_target = '0; halt = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // straight-line fetch, then backpressure on the pc 1 word
      wait_valid_pc(1);
      instr_ready = 1'b0;
      repeat (5) tick();
      instr_ready = 1'b1;
      wait_valid_pc(3);

      // wrap from 63 to 0
      pulse_branch(63);
      wait_valid_pc(0);

      // branch while the pc 4 read is in WAIT
      pulse_branch(4);
      tick();
      pulse_branch(10);
      wait_valid_pc(10);

      // halt on accept of pc 5, resume by branch to 20
      pulse_branch(5);
      wait_valid_pc(5);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      repeat (20) tick();
      pulse_branch(20);
      wait_valid_pc(20);

      // reset while the pc 7 read is in WAIT
      pulse_branch(7);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_valid_pc(0);

      // branch in the IDLE cycle is ignored
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      branch_valid = 1'b1; branch_target = 6'd30;
      tick();
      branch_valid = 1'b0;
      wait_valid_pc(0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         instr_ready   = ($urandom % 4) != 0;
         branch_valid  = ($urandom % 16) == 0;
         branch_target = AW'($urandom);
         halt          = ($urandom % 8) == 0;
         rst_n         = ($urandom % 250) != 0;
         tick();
      end
      rst_n = 1'b1; branch_valid = 1'b0; halt = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
